// File: rtl/risc_pkg.sv
// Shared datapath constants for the register file and shifter front end.
package risc_pkg;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int AW    = 3;

    // Shift-op encodings carried alongside operand B into the shifter
    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/regfile_core.sv
// General register array: one synchronous write port, two combinational read ports.
module regfile_core
    import risc_pkg::*;
#(
    parameter int P_WIDTH = WIDTH,
    parameter int P_NREGS = NREGS,
    parameter int P_AW    = AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               write,
    input  logic [P_AW-1:0]    writenum,
    input  logic [P_WIDTH-1:0] data_in,
    input  logic [P_AW-1:0]    readnum_a,
    input  logic [P_AW-1:0]    readnum_b,
    output logic [P_WIDTH-1:0] data_a,
    output logic [P_WIDTH-1:0] data_b
);

    logic [P_WIDTH-1:0] regs [P_NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < P_NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write) begin
            regs[writenum] <= data_in;
        end
    end

    assign data_a = regs[readnum_a];
    assign data_b = regs[readnum_b];

endmodule

// File: rtl/operand_regfile.sv
// Register file plus A/B operand latches and valid tracking ahead of the shifter.
// Optional WRITE_BYPASS_EN: a load from the register being written captures data_in.
module operand_regfile
    import risc_pkg::*;
#(
    parameter int P_WIDTH = WIDTH,
    parameter int P_NREGS = NREGS,
    parameter int P_AW    = AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               write,
    input  logic [P_AW-1:0]    writenum,
    input  logic [P_WIDTH-1:0] data_in,
    input  logic [P_AW-1:0]    readnum_a,
    input  logic [P_AW-1:0]    readnum_b,
    input  logic               loada,
    input  logic               loadb,
    input  logic [1:0]         shift_in,
    input  logic               consume,
    output logic [P_WIDTH-1:0] A,
    output logic [P_WIDTH-1:0] B,
    output logic [1:0]         shift,
    output logic               operands_valid
);

    logic [P_WIDTH-1:0] rd_a;
    logic [P_WIDTH-1:0] rd_b;
    logic [P_WIDTH-1:0] src_a;
    logic [P_WIDTH-1:0] src_b;
    logic               a_vld;
    logic               b_vld;
    logic               take;

    regfile_core #(
        .P_WIDTH (P_WIDTH),
        .P_NREGS (P_NREGS),
        .P_AW    (P_AW)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .write     (write),
        .writenum  (writenum),
        .data_in   (data_in),
        .readnum_a (readnum_a),
        .readnum_b (readnum_b),
        .data_a    (rd_a),
        .data_b    (rd_b)
    );

`ifdef WRITE_BYPASS_EN
    assign src_a = (write && (writenum == readnum_a)) ? data_in : rd_a;
    assign src_b = (write && (writenum == readnum_b)) ? data_in : rd_b;
`else
    assign src_a = rd_a;
    assign src_b = rd_b;
`endif

    // A consume only counts when a full pair is held; a load in the same cycle overrides it
    assign take = consume && a_vld && b_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            A     <= '0;
            a_vld <= 1'b0;
        end else if (loada) begin
            A     <= src_a;
            a_vld <= 1'b1;
        end else if (take) begin
            a_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            B     <= '0;
            shift <= SH_NONE;
            b_vld <= 1'b0;
        end else if (loadb) begin
            B     <= src_b;
            shift <= shift_in;
            b_vld <= 1'b1;
        end else if (take) begin
            b_vld <= 1'b0;
        end
    end

    assign operands_valid = a_vld & b_vld;

endmodule

// File: tb/tb_operand_regfile.sv
// Directed self-checking bench for operand_regfile; expectations follow WRITE_BYPASS_EN.
module tb_operand_regfile;
    import risc_pkg::*;

    logic             clk;
    logic             reset;
    logic             write;
    logic [AW-1:0]    writenum;
    logic [WIDTH-1:0] data_in;
    logic [AW-1:0]    readnum_a;
    logic [AW-1:0]    readnum_b;
    logic             loada;
    logic             loadb;
    logic [1:0]       shift_in;
    logic             consume;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       shift;
    logic             operands_valid;

    int compared;
    int mismatched;

    operand_regfile dut (
        .clk            (clk),
        .reset          (reset),
        .write          (write),
        .writenum       (writenum),
        .data_in        (data_in),
        .readnum_a      (readnum_a),
        .readnum_b      (readnum_b),
        .loada          (loada),
        .loadb          (loadb),
        .shift_in       (shift_in),
        .consume        (consume),
        .A              (A),
        .B              (B),
        .shift          (shift),
        .operands_valid (operands_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, clocks it in, then leaves the bench 1ns past the edge
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] wn,
                                 input logic [WIDTH-1:0] wd,
                                 input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                                 input logic la, input logic lb,
                                 input logic [1:0] sh, input logic cons);
        write     = wr;
        writenum  = wn;
        data_in   = wd;
        readnum_a = ra;
        readnum_b = rb;
        loada     = la;
        loadb     = lb;
        shift_in  = sh;
        consume   = cons;
        @(posedge clk);
        #1;
        write   = 1'b0;
        loada   = 1'b0;
        loadb   = 1'b0;
        consume = 1'b0;
    endtask

    logic [WIDTH-1:0] exp_bypass;

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        write      = 1'b0;
        writenum   = '0;
        data_in    = '0;
        readnum_a  = '0;
        readnum_b  = '0;
        loada      = 1'b0;
        loadb      = 1'b0;
        shift_in   = 2'b00;
        consume    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        checkOutput("rst_A", A, 16'h0000);
        checkOutput("rst_B", B, 16'h0000);
        checkOutput("rst_shift", {14'b0, shift}, 16'h0000);
        checkOutput("rst_valid", {15'b0, operands_valid}, 16'h0000);

        // Write R3, then load B and A from it on successive cycles
        applyStimulus(1'b1, 3'd3, 16'h1234, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b0, 3'd0, 16'h0000, 3'd0, 3'd3, 1'b0, 1'b1, SH_LSL, 1'b0);
        checkOutput("b_load", B, 16'h1234);
        checkOutput("b_shift", {14'b0, shift}, 16'h0001);
        checkOutput("valid_b_only", {15'b0, operands_valid}, 16'h0000);
        applyStimulus(1'b0, 3'd0, 16'h0000, 3'd3, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0);
        checkOutput("a_load", A, 16'h1234);
        checkOutput("valid_pair", {15'b0, operands_valid}, 16'h0001);

        // consume together with loada: A stays valid, B is retired
        applyStimulus(1'b1, 3'd2, 16'h00AA, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b0, 3'd0, 16'h0000, 3'd2, 3'd0, 1'b1, 1'b0, 2'b00, 1'b1);
        checkOutput("cons_load_valid", {15'b0, operands_valid}, 16'h0000);
        checkOutput("cons_load_A", A, 16'h00AA);
        checkOutput("cons_load_B", B, 16'h1234);

        // consume with no pair is ignored; a later loadb alone completes the pair
        applyStimulus(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b1);
        checkOutput("idle_cons_valid", {15'b0, operands_valid}, 16'h0000);
        checkOutput("idle_cons_A", A, 16'h00AA);
        checkOutput("idle_cons_shift", {14'b0, shift}, 16'h0001);
        applyStimulus(1'b0, 3'd0, 16'h0000, 3'd0, 3'd2, 1'b0, 1'b1, SH_ASR, 1'b0);
        checkOutput("a_kept_valid", {15'b0, operands_valid}, 16'h0001);
        checkOutput("asr_shift", {14'b0, shift}, 16'h0003);
        checkOutput("b_r2", B, 16'h00AA);

        // Plain consume retires the pair but leaves the data in place
        applyStimulus(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b1);
        checkOutput("consume_valid", {15'b0, operands_valid}, 16'h0000);
        checkOutput("consume_A", A, 16'h00AA);
        checkOutput("consume_B", B, 16'h00AA);

        // Same-cycle write and load of R5
        applyStimulus(1'b1, 3'd5, 16'h0001, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0);
`ifdef WRITE_BYPASS_EN
        exp_bypass = 16'hBEEF;
`else
        exp_bypass = 16'h0001;
`endif
        checkOutput("bypass_A", A, exp_bypass);
        applyStimulus(1'b0, 3'd0, 16'h0000, 3'd0, 3'd5, 1'b0, 1'b1, SH_LSR, 1'b0);
        checkOutput("r5_after_write", B, 16'hBEEF);

        // Every index holds its own value
        for (int i = 0; i < NREGS; i++) begin
            applyStimulus(1'b1, AW'(i), WIDTH'(i), 3'd0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        end
        for (int i = 0; i < NREGS; i++) begin
            applyStimulus(1'b0, 3'd0, 16'h0000, AW'(i), AW'(NREGS - 1 - i),
                          1'b1, 1'b1, 2'b00, 1'b0);
            checkOutput($sformatf("idx_A%0d", i), A, WIDTH'(i));
            checkOutput($sformatf("idx_B%0d", i), B, WIDTH'(NREGS - 1 - i));
        end

        // Async reset in the middle of a cycle after loads
        applyStimulus(1'b0, 3'd0, 16'h0000, 3'd7, 3'd6, 1'b1, 1'b1, SH_ASR, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_A", A, 16'h0000);
        checkOutput("async_B", B, 16'h0000);
        checkOutput("async_shift", {14'b0, shift}, 16'h0000);
        checkOutput("async_valid", {15'b0, operands_valid}, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            applyStimulus(1'b0, 3'd0, 16'h0000, AW'(i), AW'(i), 1'b1, 1'b1, 2'b00, 1'b0);
            checkOutput($sformatf("clr_R%0d", i), A | B, 16'h0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
